// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Moore control sequencer for a single-bus ALU datapath. One instruction is
//   fetched and executed per start request: fetch (T0-T2), operand/ALU steps
//   (T3-T4), write-back (T5, plus T6 for mul/div HI result), then a DONE pulse.
//
// Ports
//   w_clock  : clock, all state changes on the rising edge
//   w_clear  : asynchronous active-high reset, forces IDLE
//   start    : execute-one-instruction request, sampled only in IDLE
//   mem_rdy  : memory read data valid, qualifies leaving T1
//   ir       : datapath IR contents (opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15])
//   busy     : high in every state except IDLE
//   done     : one-cycle completion pulse
//   illegal  : one-cycle pulse (with done) for opcodes above 12
//   s_*      : bus source selects (at most one per state)
//   e_*, w_* : register load / control strobes
//   reg_out  : one-hot general-register bus select
//   reg_in   : one-hot general-register load enable
//   opcode   : ALU operation {1'b0, ir[31:27]} in T3/T4, else 0
module alu_sequencer #(
    parameter int NUM_REGS = 16
) (
    input  logic                w_clock,
    input  logic                w_clear,
    input  logic                start,
    input  logic                mem_rdy,
    input  logic [31:0]         ir,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                s_PC,
    output logic                s_MDR,
    output logic                s_Zlow,
    output logic                s_Zhigh,
    output logic                e_MAR,
    output logic                e_PC,
    output logic                e_MDR,
    output logic                e_IR,
    output logic                e_Y,
    output logic                e_Z,
    output logic                e_HI,
    output logic                e_LO,
    output logic                e_alu,
    output logic                w_IncPC,
    output logic                w_read,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [5:0]          opcode
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
    } state_t;

    state_t state, state_nxt;

    // pc_loaded: already spent one cycle in T1, so PC must not load again while
    // waiting on memory. bad_op: DONE was reached via the illegal-opcode path.
    logic pc_loaded;
    logic bad_op;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_mul_div, is_unary, is_illegal;

    assign op = ir[31:27];
    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];

    assign is_mul_div = (op == 5'd5) || (op == 5'd6);
    assign is_unary   = (op == 5'd4) || (op == 5'd12);
    assign is_illegal = (op > 5'd12);

    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        onehot = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == i) onehot[i] = 1'b1;
        end
    endfunction

    always_ff @(posedge w_clock or posedge w_clear) begin
        if (w_clear) begin
            state     <= IDLE;
            pc_loaded <= 1'b0;
            bad_op    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc_loaded <= (state == T1);
            bad_op    <= (state == T2) && is_illegal;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        illegal   = 1'b0;
        s_PC      = 1'b0;
        s_MDR     = 1'b0;
        s_Zlow    = 1'b0;
        s_Zhigh   = 1'b0;
        e_MAR     = 1'b0;
        e_PC      = 1'b0;
        e_MDR     = 1'b0;
        e_IR      = 1'b0;
        e_Y       = 1'b0;
        e_Z       = 1'b0;
        e_HI      = 1'b0;
        e_LO      = 1'b0;
        e_alu     = 1'b0;
        w_IncPC   = 1'b0;
        w_read    = 1'b0;
        reg_out   = '0;
        reg_in    = '0;
        opcode    = '0;

        case (state)
            IDLE: begin
                if (start) state_nxt = T0;
            end
            T0: begin
                s_PC      = 1'b1;
                e_MAR     = 1'b1;
                w_IncPC   = 1'b1;
                e_Z       = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                s_Zlow = 1'b1;
                e_PC   = !pc_loaded;
                w_read = 1'b1;
                e_MDR  = 1'b1;
                if (mem_rdy) state_nxt = T2;
            end
            T2: begin
                s_MDR = 1'b1;
                e_IR  = 1'b1;
                if (is_illegal)    state_nxt = DONE;
                else if (is_unary) state_nxt = T4;
                else               state_nxt = T3;
            end
            T3: begin
                reg_out   = onehot(rb);
                e_Y       = 1'b1;
                opcode    = {1'b0, op};
                state_nxt = T4;
            end
            T4: begin
                reg_out   = is_unary ? onehot(rb) : onehot(rc);
                e_alu     = 1'b1;
                e_Z       = 1'b1;
                opcode    = {1'b0, op};
                state_nxt = T5;
            end
            T5: begin
                s_Zlow = 1'b1;
                if (is_mul_div) begin
                    e_LO      = 1'b1;
                    state_nxt = T6;
                end else begin
                    reg_in    = onehot(ra);
                    state_nxt = DONE;
                end
            end
            T6: begin
                s_Zhigh   = 1'b1;
                e_HI      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                illegal   = bad_op;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Directed self-checking bench for alu_sequencer. Each scenario task drives
//   one or more instructions, captures the outputs once per cycle on the
//   falling edge, and compares against hand-computed expectations.
module tb_alu_sequencer;

    logic        w_clock = 1'b0;
    logic        w_clear = 1'b1;
    logic        start   = 1'b0;
    logic        mem_rdy = 1'b1;
    logic [31:0] ir      = '0;
    logic        busy, done, illegal;
    logic        s_PC, s_MDR, s_Zlow, s_Zhigh;
    logic        e_MAR, e_PC, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO, e_alu, w_IncPC, w_read;
    logic [15:0] reg_out, reg_in;
    logic [5:0]  opcode;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        busy, done, illegal;
        logic        s_PC, s_MDR, s_Zlow, s_Zhigh;
        logic        e_MAR, e_PC, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO, e_alu, w_IncPC, w_read;
        logic [15:0] reg_out, reg_in;
        logic [5:0]  opcode;
    } snap_t;

    snap_t all_out;
    snap_t snap [0:47];

    assign all_out = {busy, done, illegal, s_PC, s_MDR, s_Zlow, s_Zhigh,
                      e_MAR, e_PC, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO, e_alu, w_IncPC, w_read,
                      reg_out, reg_in, opcode};

    alu_sequencer #(.NUM_REGS(16)) dut (
        .w_clock (w_clock), .w_clear (w_clear), .start (start), .mem_rdy (mem_rdy), .ir (ir),
        .busy (busy), .done (done), .illegal (illegal),
        .s_PC (s_PC), .s_MDR (s_MDR), .s_Zlow (s_Zlow), .s_Zhigh (s_Zhigh),
        .e_MAR (e_MAR), .e_PC (e_PC), .e_MDR (e_MDR), .e_IR (e_IR), .e_Y (e_Y), .e_Z (e_Z),
        .e_HI (e_HI), .e_LO (e_LO), .e_alu (e_alu), .w_IncPC (w_IncPC), .w_read (w_read),
        .reg_out (reg_out), .reg_in (reg_in), .opcode (opcode)
    );

    always #5 w_clock = ~w_clock;

    // Runs one instruction. snap[k] holds the outputs k cycles after the
    // start-sampling edge; lat is the first k with done high (0 on timeout).
    // One extra snapshot (lat+1) is taken after done.
    task automatic run_op(input logic [31:0] i_ir, input int waits, input bit hold, output int lat);
        int t1;
        lat = 0;
        t1  = 0;
        for (int k = 0; k < 48; k++) snap[k] = '0;
        @(negedge w_clock);
        ir      = i_ir;
        start   = 1'b1;
        mem_rdy = 1'b1;
        @(posedge w_clock);
        for (int k = 1; k < 40; k++) begin
            @(negedge w_clock);
            snap[k] = all_out;
            if (!hold) start = 1'b0;
            if (w_read) begin
                mem_rdy = (t1 >= waits);
                t1++;
            end else begin
                mem_rdy = 1'b1;
            end
            if (lat != 0) begin
                start = 1'b0;
                break;
            end
            if (done) lat = k;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        int seen;
        w_clear = 1'b1;
        start   = 1'b1;
        repeat (2) @(posedge w_clock);
        @(negedge w_clock);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        w_clear = 1'b0;
        @(posedge w_clock);
        #1;
        checks++;
        if ({busy, s_PC, e_MAR} !== 3'b111) begin
            errors++;
            $display("FAIL first_start_after_reset: busy/s_PC/e_MAR got %b want 111", {busy, s_PC, e_MAR});
        end
        start = 1'b0;
        seen  = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge w_clock);
            if (done) seen = 1;
        end
        @(negedge w_clock);
        checks++;
        if (seen != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: done_seen %0d busy %b want 1 0", seen, busy);
        end
    endtask

    task automatic test_mul;
        int lat;
        logic [15:0] ri_any;
        run_op(32'h28918000, 0, 1'b0, lat);
        ri_any = '0;
        for (int k = 1; k <= 8; k++) ri_any |= snap[k].reg_in;
        checks++;
        if (lat != 8) begin errors++; $display("FAIL mul_latency: got %0d want 8", lat); end
        checks++;
        if ({snap[1].s_PC, snap[1].e_MAR, snap[1].w_IncPC, snap[1].e_Z} !== 4'hF) begin
            errors++; $display("FAIL mul_t0_strobes: got %b want 1111",
                {snap[1].s_PC, snap[1].e_MAR, snap[1].w_IncPC, snap[1].e_Z});
        end
        checks++;
        if (snap[5].reg_out !== 16'h0008 || snap[5].opcode !== 6'd5 || snap[5].e_alu !== 1'b1) begin
            errors++; $display("FAIL mul_t4: reg_out %h opcode %0d e_alu %b want 0008 5 1",
                snap[5].reg_out, snap[5].opcode, snap[5].e_alu);
        end
        checks++;
        if ({snap[6].s_Zlow, snap[6].e_LO, snap[7].s_Zhigh, snap[7].e_HI} !== 4'hF) begin
            errors++; $display("FAIL mul_lo_hi: got %b want 1111",
                {snap[6].s_Zlow, snap[6].e_LO, snap[7].s_Zhigh, snap[7].e_HI});
        end
        checks++;
        if (ri_any !== 16'h0000) begin errors++; $display("FAIL mul_reg_in: got %h want 0000", ri_any); end
        checks++;
        if (snap[9].busy !== 1'b0) begin errors++; $display("FAIL mul_idle_after: busy %b want 0", snap[9].busy); end
    endtask

    task automatic test_add;
        int lat;
        logic hilo;
        run_op(32'h00918000, 0, 1'b0, lat);
        hilo = 1'b0;
        for (int k = 1; k <= 8; k++) hilo |= snap[k].e_HI | snap[k].e_LO;
        checks++;
        if (lat != 7) begin errors++; $display("FAIL add_latency: got %0d want 7", lat); end
        checks++;
        if (snap[4].reg_out !== 16'h0004 || snap[4].e_Y !== 1'b1) begin
            errors++; $display("FAIL add_t3: reg_out %h e_Y %b want 0004 1", snap[4].reg_out, snap[4].e_Y);
        end
        checks++;
        if (snap[5].reg_out !== 16'h0008 || snap[5].e_Z !== 1'b1) begin
            errors++; $display("FAIL add_t4: reg_out %h e_Z %b want 0008 1", snap[5].reg_out, snap[5].e_Z);
        end
        checks++;
        if (snap[6].reg_in !== 16'h0002 || snap[6].s_Zlow !== 1'b1) begin
            errors++; $display("FAIL add_t5: reg_in %h s_Zlow %b want 0002 1", snap[6].reg_in, snap[6].s_Zlow);
        end
        checks++;
        if (hilo !== 1'b0) begin errors++; $display("FAIL add_hilo: got %b want 0", hilo); end
    endtask

    task automatic test_unary;
        int lat;
        logic ey;
        run_op(32'h60900000, 0, 1'b0, lat);
        ey = 1'b0;
        for (int k = 1; k <= 7; k++) ey |= snap[k].e_Y;
        checks++;
        if (lat != 6) begin errors++; $display("FAIL neg_latency: got %0d want 6", lat); end
        checks++;
        if (ey !== 1'b0) begin errors++; $display("FAIL neg_no_t3: e_Y got %b want 0", ey); end
        checks++;
        if (snap[4].reg_out !== 16'h0004 || snap[4].opcode !== 6'd12) begin
            errors++; $display("FAIL neg_t4: reg_out %h opcode %0d want 0004 12", snap[4].reg_out, snap[4].opcode);
        end
        checks++;
        if (snap[5].reg_in !== 16'h0002) begin errors++; $display("FAIL neg_t5: reg_in %h want 0002", snap[5].reg_in); end
        // not (opcode 4) takes the same short path
        run_op(32'h20900000, 0, 1'b0, lat);
        checks++;
        if (lat != 6 || snap[4].opcode !== 6'd4 || snap[5].reg_in !== 16'h0002) begin
            errors++; $display("FAIL not_path: lat %0d opcode %0d reg_in %h want 6 4 0002",
                lat, snap[4].opcode, snap[5].reg_in);
        end
    endtask

    task automatic test_mem_wait;
        int lat, n_read, n_mdr, n_pc;
        run_op(32'h00918000, 3, 1'b0, lat);
        n_read = 0; n_mdr = 0; n_pc = 0;
        for (int k = 1; k <= 12; k++) begin
            n_read += int'(snap[k].w_read);
            n_mdr  += int'(snap[k].e_MDR);
            n_pc   += int'(snap[k].e_PC);
        end
        checks++;
        if (lat != 10) begin errors++; $display("FAIL wait_latency: got %0d want 10", lat); end
        checks++;
        if (n_read != 4 || n_mdr != 4) begin
            errors++; $display("FAIL wait_read_cycles: w_read %0d e_MDR %0d want 4 4", n_read, n_mdr);
        end
        checks++;
        if (n_pc != 1) begin errors++; $display("FAIL wait_pc_once: e_PC cycles %0d want 1", n_pc); end
    endtask

    task automatic test_illegal;
        int lat, n_ill;
        logic late;
        run_op(32'hF8000000, 0, 1'b0, lat);
        n_ill = 0; late = 1'b0;
        for (int k = 1; k <= 5; k++) n_ill += int'(snap[k].illegal);
        for (int k = 2; k <= 5; k++) late |= snap[k].e_Y | snap[k].e_Z | snap[k].e_alu;
        checks++;
        if (lat != 4 || snap[4].illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_31: lat %0d illegal %b want 4 1", lat, snap[4].illegal);
        end
        checks++;
        if (n_ill != 1 || late !== 1'b0) begin
            errors++; $display("FAIL illegal_pulse: pulses %0d alu_strobes %b want 1 0", n_ill, late);
        end
        run_op(32'h68000000, 0, 1'b0, lat);
        checks++;
        if (lat != 4 || snap[4].illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_13: lat %0d illegal %b want 4 1", lat, snap[4].illegal);
        end
        run_op(32'h60900000, 0, 1'b0, lat);
        n_ill = 0;
        for (int k = 1; k <= 7; k++) n_ill += int'(snap[k].illegal);
        checks++;
        if (n_ill != 0) begin errors++; $display("FAIL legal_12: illegal pulses %0d want 0", n_ill); end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(32'h00918000, 0, 1'b1, lat);
        checks++;
        if (lat != 7 || snap[8].busy !== 1'b0) begin
            errors++; $display("FAIL start_held: lat %0d busy_after %b want 7 0", lat, snap[8].busy);
        end
        run_op(32'h28918000, 0, 1'b0, lat);
        checks++;
        if (lat != 8) begin errors++; $display("FAIL back_to_back: lat %0d want 8", lat); end
    endtask

    task automatic test_reset_mid;
        int found, lat;
        found = 0;
        @(negedge w_clock);
        ir = 32'h00918000; start = 1'b1; mem_rdy = 1'b1;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge w_clock);
            start = 1'b0;
            if (e_alu) found = 1;
        end
        #1 w_clear = 1'b1;
        #1;
        checks++;
        if (found != 1 || all_out !== '0) begin
            errors++; $display("FAIL reset_mid: reached_t4 %0d outputs %h want 1 0", found, all_out);
        end
        @(negedge w_clock);
        w_clear = 1'b0;
        run_op(32'h00918000, 0, 1'b0, lat);
        checks++;
        if (lat != 7 || snap[4].e_Y !== 1'b1 || snap[6].reg_in !== 16'h0002) begin
            errors++; $display("FAIL reset_mid_rerun: lat %0d e_Y %b reg_in %h want 7 1 0002",
                lat, snap[4].e_Y, snap[6].reg_in);
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_add;
        test_unary;
        test_mem_wait;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter NUM_REGS, 16, width of one-hot register select/enable vectors; IR register fields are 4 bits.
REQ-002 w_clock  in  1  single clock; all state changes on rising edge.
REQ-003 w_clear  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request to execute one instruction; sampled only in IDLE.
REQ-005 mem_rdy  in  1  memory read data valid on Mdatain; qualifies T1.
REQ-006 ir  in  32  datapath IR contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse on instruction completion.
REQ-009 illegal  out  1  one-cycle pulse when opcode > 12 is decoded.
REQ-010 s_PC, s_MDR, s_Zlow, s_Zhigh  out  1 each  bus source selects.
REQ-011 e_MAR, e_PC, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO, e_alu, w_IncPC, w_read  out  1 each  load/control strobes.
REQ-012 reg_out  out  NUM_REGS  one-hot general-register bus select.
REQ-013 reg_in  out  NUM_REGS  one-hot general-register load enable.
REQ-014 opcode  out  6  ALU operation, {1'b0, ir[31:27]}.

Function
REQ-015 States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE; all outputs decoded from state only (Moore), at most one bus source asserted per state.
REQ-016 IDLE: all strobes/selects 0, opcode 0; start=1 -> T0, else stay.
REQ-017 T0: s_PC, e_MAR, w_IncPC, e_Z = 1; -> T1.
REQ-018 T1: s_Zlow, e_PC, w_read, e_MDR = 1; mem_rdy=0 -> stay in T1 with e_PC=0 (PC loads exactly once), mem_rdy=1 -> T2.
REQ-019 T2: s_MDR, e_IR = 1; -> T3 for binary ops (0-3, 5-11), -> T4 for unary ops not=4, neg=12, -> DONE with illegal=1 for opcode 13-31.
REQ-020 Opcode map: add 0, sub 1, and 2, or 3, not 4, mul 5, div 6, rol 7, ror 8, shr 9, shra 10, shl 11, neg 12.
REQ-021 T3: reg_out = onehot(Rb), e_Y = 1; -> T4.
REQ-022 T4: reg_out = onehot(Rc) for binary ops, onehot(Rb) for unary ops; e_alu, e_Z = 1; opcode driven; -> T5.
REQ-023 opcode output equals {1'b0, ir[31:27]} in T3 and T4, 0 in all other states.
REQ-024 T5: s_Zlow = 1; mul/div: e_LO = 1, -> T6; all others: reg_in = onehot(Ra), -> DONE.
REQ-025 T6: s_Zhigh, e_HI = 1; -> DONE.
REQ-026 DONE: done = 1 for one cycle, busy = 1; -> IDLE; start in DONE ignored.
REQ-027 start while busy has no effect; no queuing.
REQ-028 Latency from start-sampling edge to done high: mul/div 8 cycles, other binary 7, unary 6, illegal 4, each plus extra T1 wait cycles.
REQ-029 ir sampled combinationally from T3 onward; changes to ir before T3 do not affect path selection except in T2.

Reset
REQ-030 w_clear=1 forces IDLE immediately, asynchronously, from any state including T1 wait.
REQ-031 During and after reset all outputs 0 (busy, done, illegal, all strobes, reg_out, reg_in, opcode).
REQ-032 First start is accepted on the first rising edge after w_clear deasserts.

Verification
REQ-033 mul: start=1, mem_rdy=1, ir=0x28918000 -> T4 reg_out=0x0008 (R3) with opcode=5; T5 e_LO; T6 e_HI; done 8 cycles after start; reg_in never asserted.
REQ-034 add: ir=0x00918000 -> T3 reg_out=0x0004, T4 reg_out=0x0008, T5 reg_in=0x0002; done at cycle 7; e_HI/e_LO never asserted.
REQ-035 neg: ir=0x60900000 -> no T3 (e_Y never high), T4 reg_out=0x0004, opcode=12, T5 reg_in=0x0002; done at cycle 6.
REQ-036 mem wait: mem_rdy held 0 for 3 cycles in T1 -> w_read/e_MDR high 4 cycles, e_PC high 1 cycle only, done delayed by 3.
REQ-037 illegal: ir=0xF8000000 -> illegal and done pulse together 4 cycles after start; no e_Y/e_Z/e_alu after T0.
REQ-038 reset mid-op: w_clear pulse during T4 -> all outputs 0 before next edge, busy=0; subsequent start runs a full clean sequence.
